// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch port and the LSU data port. One transaction is outstanding at a time.
// Data has priority; after MAX_STREAK consecutive data grants taken while
// fetch waits, fetch is forced through.
//
// Optional build macro: ARB_TIMEOUT_EN
//   defined   - response watchdog: after TIMEOUT RESP cycles with no
//               m_rvalid_i, the owner gets rvalid with zero data and err_o
//               pulses for that cycle.
//   undefined - RESP waits indefinitely, err_o is tied 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction, arbitrating incoming requests
// REQ   | m_req_o asserted for the owner, waiting for m_gnt_i
// RESP  | request accepted, waiting for m_rvalid_i (or timeout)

module mem_port_arbiter #(
  parameter int MAX_STREAK = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_gnt_i,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state, state_nxt;
  logic            owner_d, owner_nxt;      // 1 = data port owns the memory
  logic [SW-1:0]   streak, streak_nxt;
  logic            tmo;
  logic            done;
  logic            arb_en;
  logic            any_req;
  logic            pick_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt;

  // Watchdog: held at zero outside RESP, so it starts from zero on every entry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
    end else if (state != RESP) begin
      tmo_cnt <= '0;
    end else if (!m_rvalid_i) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // A real response in the same cycle wins over the watchdog
  assign tmo = (state == RESP) && !m_rvalid_i && (tmo_cnt == CW'(TIMEOUT));
`else
  assign tmo = 1'b0;
`endif

  assign done    = (state == RESP) && (m_rvalid_i || tmo);
  assign arb_en  = (state == IDLE) || done;
  assign any_req = if_req_i || d_req_i;
  assign pick_d  = d_req_i && !(if_req_i && (streak == SW'(MAX_STREAK)));

  // State register together with the owner and streak latched at arbitration
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      owner_d <= 1'b1;
      streak  <= '0;
    end else begin
      state   <= state_nxt;
      owner_d <= owner_nxt;
      streak  <= streak_nxt;
    end
  end

  // Next-state, owner and streak selection
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner_d;
    streak_nxt = streak;
    case (state)
      IDLE:    if (any_req) state_nxt = REQ;
      REQ:     if (m_gnt_i) state_nxt = RESP;
      RESP:    if (done)    state_nxt = any_req ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (arb_en && any_req) begin
      owner_nxt = pick_d;
      if (pick_d && if_req_i) begin
        streak_nxt = (streak == SW'(MAX_STREAK)) ? streak : streak + 1'b1;
      end else begin
        streak_nxt = '0;
      end
    end
  end

  // Memory-side request and port-side grant/response routing
  always_comb begin
    m_req_o     = 1'b0;
    m_we_o      = 1'b0;
    m_be_o      = 4'h0;
    m_addr_o    = 32'h0;
    m_wdata_o   = 32'h0;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = 32'h0;
    d_gnt_o     = 1'b0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = 32'h0;
    busy_o      = (state != IDLE);
    err_o       = tmo;
    case (state)
      REQ: begin
        m_req_o = 1'b1;
        if (owner_d) begin
          m_we_o    = d_we_i;
          m_be_o    = d_be_i;
          m_addr_o  = d_addr_i;
          m_wdata_o = d_wdata_i;
          d_gnt_o   = m_gnt_i;
        end else begin
          m_be_o    = 4'hF;
          m_addr_o  = if_addr_i;
          if_gnt_o  = m_gnt_i;
        end
      end
      RESP: begin
        if (done) begin
          if (owner_d) begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = tmo ? 32'h0 : m_rdata_i;
          end else begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = tmo ? 32'h0 : m_rdata_i;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
